mac_window_sequencer: RTL and testbench
=======================================

Name: mac_window_sequencer

Overview:
- Initiator that drives the convolution MAC datapath over one image frame.
- Slides a FILT_DIM x FILT_DIM window at stride 1 over an IMG_W x IMG_W image, one valid output position at a time.
- For each window it fetches image and filter bytes from the buffers, presents them as img_pixel/filter_value, and sequences rst_acc/acc_en.
- It flags each finished accumulation with res_valid plus the output coordinate, so the downstream writer captures the MAC's 12-bit out.

Parameters:
- IMG_W, 8, image width and height in pixels (square image).
- FILT_DIM, 4, filter width and height; taps per window N = FILT_DIM*FILT_DIM.
- ADDR_W, 6, image buffer address width; must be >= clog2(IMG_W*IMG_W).
- FADDR_W, 4, filter buffer address width; must be >= clog2(N).
- POS_W, 3, width of the output coordinates; must be >= clog2(IMG_W-FILT_DIM+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to process one frame; honoured only in IDLE.
- busy  out  1  high from the first CLEAR through the final RESULT.
- rd_en  out  1  buffer read strobe; registered.
- img_addr  out  ADDR_W  image read address; registered.
- filt_addr  out  FADDR_W  filter read address; registered.
- img_data  in  8  image buffer read data; valid exactly 1 cycle after rd_en.
- filt_data  in  8  filter buffer read data; valid exactly 1 cycle after rd_en.
- img_pixel  out  8  combinational pass-through of img_data to the MAC.
- filter_value  out  8  combinational pass-through of filt_data to the MAC.
- rst_acc  out  1  clears the MAC accumulator; registered.
- acc_en  out  1  MAC accumulate enable; registered copy of rd_en, delayed 1 cycle.
- res_valid  out  1  1-cycle pulse: the MAC out holds the finished window sum.
- res_row  out  POS_W  output row of the current window; held stable while busy.
- res_col  out  POS_W  output column of the current window; held stable while busy.
- frame_done  out  1  1-cycle pulse, coincident with the last res_valid.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- OUT_DIM = IMG_W-FILT_DIM+1. Windows are processed in row-major order: (r,c) runs (0,0) to (OUT_DIM-1,OUT_DIM-1).
- FSM states:
  - IDLE: start=1 -> CLEAR; r=c=0.
  - CLEAR: 1 cycle, rst_acc=1 -> FETCH; tap counter k=0.
  - FETCH: exactly N cycles. Each cycle: rd_en=1, img_addr=(r+k/FILT_DIM)*IMG_W + c + k%FILT_DIM, filt_addr=k, then k++. After tap N-1 -> DRAIN.
  - DRAIN: 1 cycle, rd_en=0; acc_en is still high for the last tap -> RESULT.
  - RESULT: 1 cycle, res_valid=1.
    - If last window: frame_done=1 -> IDLE.
    - Else: advance c; on c wrap to 0, increment r -> CLEAR.
- Output timing:
  - rst_acc, rd_en and the addresses are registered on state entry, so they are valid during the cycle the state occupies.
  - acc_en is high for exactly N cycles per window, beginning 1 cycle after the first rd_en.
  - Address arithmetic is unsigned with no wrap; windows never cross the image edge.
- Latency:
  - Per window: N+3 cycles from CLEAR to RESULT inclusive (19 for defaults).
  - Per frame: OUT_DIM*OUT_DIM*(N+3) cycles (475 for defaults).
  - busy rises the cycle after start is sampled.
- Boundary conditions:
  - start while busy: ignored, with no effect on state or counters.
  - start in the same cycle as RESULT of the last window: ignored; a new frame needs start while in IDLE.
  - rst asserted at any point (mid-FETCH included): immediate return to IDLE with all outputs 0. No res_valid or frame_done is issued for the aborted window. The accumulator is cleared by the next CLEAR.
  - rst_acc and acc_en are never high in the same cycle.
  - res_row/res_col return to 0 in IDLE.

Test Plan:
- Reset, then start with all image bytes = 1 and all filter bytes = 1:
  - exactly 25 res_valid pulses.
  - MAC out = 16 at each res_valid.
  - frame_done coincides with the 25th pulse, 475 cycles after busy rises.
  - busy falls the next cycle.
- Address trace, window (0,0): img_addr = 0,1,2,3,8,9,10,11,16,17,18,19,24,25,26,27 and filt_addr = 0..15. Window (1,2) first img_addr = 10, last = 37.
- Handshake timing per window:
  - rst_acc is high for 1 cycle.
  - rd_en is high for 16 consecutive cycles.
  - acc_en is the same 16-cycle pattern shifted +1.
  - res_valid follows 1 cycle after acc_en falls.
  - rst_acc and acc_en never overlap.
- start pulsed at cycle 5 and again mid-frame: frame still produces exactly 25 results with unchanged coordinate sequence (0,0),(0,1)...(4,4).
- rst asserted during FETCH of window (2,3), then released and start issued:
  - all outputs 0 during reset.
  - no res_valid for (2,3).
  - new frame begins at (0,0), and its first result is correct (accumulator cleared by CLEAR).
- Image byte = row index, filter byte = 2: result at (r,c) = 2*4*(4r+6) = 32r+48, e.g. 48 at (0,*) and 176 at (4,*).

Source files
------------

// File: rtl/mac_window_sequencer.sv
// Frame sequencer for the convolution MAC: slides a FILT_DIM x FILT_DIM window over
// an IMG_W x IMG_W image, fetching taps and framing each accumulation with rst_acc/acc_en.
module mac_window_sequencer #(
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned FILT_DIM = 4,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned FADDR_W  = 4,
  parameter int unsigned POS_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  img_addr,
  output logic [FADDR_W-1:0] filt_addr,
  input  logic [7:0]         img_data,
  input  logic [7:0]         filt_data,
  output logic [7:0]         img_pixel,
  output logic [7:0]         filter_value,
  output logic               rst_acc,
  output logic               acc_en,
  output logic               res_valid,
  output logic [POS_W-1:0]   res_row,
  output logic [POS_W-1:0]   res_col,
  output logic               frame_done
);

  localparam int unsigned N       = FILT_DIM * FILT_DIM;
  localparam int unsigned OUT_DIM = IMG_W - FILT_DIM + 1;
  localparam int unsigned TAP_W   = (FILT_DIM > 1) ? $clog2(FILT_DIM) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, RESULT} state_t;

  state_t           state;
  logic [TAP_W-1:0] tr, tc;
  logic [TAP_W-1:0] next_tr, next_tc;
  logic             last_win;

  assign img_pixel    = img_data;
  assign filter_value = filt_data;
  assign last_win     = (res_row == POS_W'(OUT_DIM - 1)) && (res_col == POS_W'(OUT_DIM - 1));

  function automatic logic [ADDR_W-1:0] tap_addr(input logic [POS_W-1:0] row,
                                                 input logic [POS_W-1:0] col,
                                                 input logic [TAP_W-1:0] trow,
                                                 input logic [TAP_W-1:0] tcol);
    return ADDR_W'((32'(row) + 32'(trow)) * 32'(IMG_W) + 32'(col) + 32'(tcol));
  endfunction

  always_comb begin
    next_tc = tc + TAP_W'(1);
    next_tr = tr;
    if (tc == TAP_W'(FILT_DIM - 1)) begin
      next_tc = '0;
      next_tr = tr + TAP_W'(1);
    end
  end

  // filt_addr doubles as the tap counter; res_row/res_col double as the window counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      rd_en      <= 1'b0;
      img_addr   <= '0;
      filt_addr  <= '0;
      rst_acc    <= 1'b0;
      acc_en     <= 1'b0;
      res_valid  <= 1'b0;
      res_row    <= '0;
      res_col    <= '0;
      frame_done <= 1'b0;
      tr         <= '0;
      tc         <= '0;
    end else begin
      acc_en     <= rd_en;
      rst_acc    <= 1'b0;
      res_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            rst_acc <= 1'b1;
            res_row <= '0;
            res_col <= '0;
          end
        end
        CLEAR: begin
          state     <= FETCH;
          rd_en     <= 1'b1;
          filt_addr <= '0;
          tr        <= '0;
          tc        <= '0;
          img_addr  <= tap_addr(res_row, res_col, '0, '0);
        end
        FETCH: begin
          if (filt_addr == FADDR_W'(N - 1)) begin
            state     <= DRAIN;
            rd_en     <= 1'b0;
            img_addr  <= '0;
            filt_addr <= '0;
            tr        <= '0;
            tc        <= '0;
          end else begin
            filt_addr <= filt_addr + FADDR_W'(1);
            tr        <= next_tr;
            tc        <= next_tc;
            img_addr  <= tap_addr(res_row, res_col, next_tr, next_tc);
          end
        end
        DRAIN: begin
          state      <= RESULT;
          res_valid  <= 1'b1;
          frame_done <= last_win;
        end
        RESULT: begin
          if (last_win) begin
            state   <= IDLE;
            busy    <= 1'b0;
            res_row <= '0;
            res_col <= '0;
          end else begin
            state   <= CLEAR;
            rst_acc <= 1'b1;
            if (res_col == POS_W'(OUT_DIM - 1)) begin
              res_col <= '0;
              res_row <= res_row + POS_W'(1);
            end else begin
              res_col <= res_col + POS_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_window_sequencer.sv
// Bench for mac_window_sequencer: buffer + MAC models, and a frame-schedule model that
// predicts every output cycle-by-cycle from the window index and phase within the window.
module tb_mac_window_sequencer;

  localparam int IMG_W = 8;
  localparam int F     = 4;
  localparam int OUT   = IMG_W - F + 1;
  localparam int N     = F * F;
  localparam int WIN   = N + 3;
  localparam int FRAME = OUT * OUT * WIN;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, rd_en, rst_acc, acc_en, res_valid, frame_done;
  logic [5:0] img_addr;
  logic [3:0] filt_addr;
  logic [7:0] img_data = 8'd0;
  logic [7:0] filt_data = 8'd0;
  logic [7:0] img_pixel, filter_value;
  logic [2:0] res_row, res_col;

  logic [7:0]  img_mem  [64];
  logic [7:0]  filt_mem [16];
  logic [11:0] acc = 12'd0;

  int tests = 0;
  int fails = 0;
  bit m_active = 1'b0;
  int t = 0;
  int mode = 0;
  int nvalid = 0;
  int busy_run = 0;
  int exp00 [16] = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19, 24, 25, 26, 27};

  always #5 clk = ~clk;

  mac_window_sequencer #(
    .IMG_W(8), .FILT_DIM(4), .ADDR_W(6), .FADDR_W(4), .POS_W(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .rd_en(rd_en),
    .img_addr(img_addr), .filt_addr(filt_addr), .img_data(img_data),
    .filt_data(filt_data), .img_pixel(img_pixel), .filter_value(filter_value),
    .rst_acc(rst_acc), .acc_en(acc_en), .res_valid(res_valid),
    .res_row(res_row), .res_col(res_col), .frame_done(frame_done)
  );

  // Synchronous-read buffers and a 12-bit MAC, as seen by the sequencer.
  always @(posedge clk) begin
    if (rd_en) begin
      img_data  <= img_mem[img_addr];
      filt_data <= filt_mem[filt_addr];
    end
    if (rst_acc) acc <= 12'd0;
    else if (acc_en) acc <= acc + 12'({8'd0, img_pixel} * {8'd0, filter_value});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] win_sum(input int r, input int c);
    int s = 0;
    for (int i = 0; i < F; i++)
      for (int j = 0; j < F; j++)
        s += img_mem[(r + i) * IMG_W + c + j] * filt_mem[i * F + j];
    return 12'(s);
  endfunction

  // Frame model: one accepted start begins FRAME cycles of activity, indexed by t.
  always @(posedge clk) begin
    if (rst) m_active <= 1'b0;
    else if (m_active) begin
      if (t == FRAME - 1) m_active <= 1'b0;
      t <= t + 1;
    end else if (start) begin
      m_active <= 1'b1;
      t <= 0;
    end
  end

  always @(negedge clk) begin
    int p, w, k, er, ec;
    bit e_busy, e_rst, e_rd, e_acc, e_val, e_fd;
    p = 0; w = 0; k = 0; er = 0; ec = 0;
    e_busy = 0; e_rst = 0; e_rd = 0; e_acc = 0; e_val = 0; e_fd = 0;
    if (!rst && m_active) begin
      p = t % WIN;
      w = t / WIN;
      er = w / OUT;
      ec = w % OUT;
      k = p - 1;
      e_busy = 1;
      e_rst = (p == 0);
      e_rd  = (p >= 1 && p <= N);
      e_acc = (p >= 2 && p <= N + 1);
      e_val = (p == N + 2);
      e_fd  = e_val && (w == OUT * OUT - 1);
    end
    busy_run = busy ? busy_run + 1 : 0;
    if (res_valid) nvalid++;
    check("img_pixel", 32'(img_pixel), 32'(img_data));
    check("filter_value", 32'(filter_value), 32'(filt_data));
    check("busy", 32'(busy), 32'(e_busy));
    check("rst_acc", 32'(rst_acc), 32'(e_rst));
    check("rd_en", 32'(rd_en), 32'(e_rd));
    check("acc_en", 32'(acc_en), 32'(e_acc));
    check("res_valid", 32'(res_valid), 32'(e_val));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("res_row", 32'(res_row), 32'(er));
    check("res_col", 32'(res_col), 32'(ec));
    check("no_overlap", 32'(rst_acc & acc_en), 32'(0));
    if (rst) begin
      check("img_addr_rst", 32'(img_addr), 32'(0));
      check("filt_addr_rst", 32'(filt_addr), 32'(0));
    end else if (e_rd) begin
      check("img_addr", 32'(img_addr), 32'((er + k / F) * IMG_W + ec + k % F));
      check("filt_addr", 32'(filt_addr), 32'(k));
      if (w == 0) check("img_addr_w00", 32'(img_addr), 32'(exp00[k]));
      if (w == 7 && k == 0) check("img_addr_w12_first", 32'(img_addr), 32'(10));
      if (w == 7 && k == N - 1) check("img_addr_w12_last", 32'(img_addr), 32'(37));
    end
    if (e_val) begin
      check("mac_out", 32'(acc), 32'(win_sum(er, ec)));
      if (mode == 1) check("mac_out_ones", 32'(acc), 32'(16));
      if (mode == 2) check("mac_out_rows", 32'(acc), 32'(32 * er + 48));
    end
    if (frame_done) check("frame_len", 32'(busy_run), 32'(FRAME));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit spam);
    bit done = 0;
    for (int i = 0; i < FRAME + 50; i++) begin
      start = spam ? ($urandom_range(0, 5) == 0) : 1'b0;
      tick();
      if (frame_done) begin
        done = 1;
        break;
      end
    end
    check("frame_done_seen", 32'(done), 32'(1));
  endtask

  task automatic fill(input int kind);
    for (int a = 0; a < 64; a++)
      img_mem[a] = (kind == 1) ? 8'd1 : (kind == 2) ? 8'(a / IMG_W) : 8'($urandom);
    for (int a = 0; a < 16; a++)
      filt_mem[a] = (kind == 1) ? 8'd1 : (kind == 2) ? 8'd2 : 8'($urandom);
  endtask

  initial begin
    fill(1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // All-ones frame with stray starts early and mid-frame, then start on the last RESULT.
    mode = 1;
    nvalid = 0;
    start_frame();
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (200) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    check("ones_count", 32'(nvalid), 32'(25));
    check("start_at_last_ignored", 32'(busy), 32'(0));

    // Row-index image, filter of 2s.
    fill(2);
    mode = 2;
    nvalid = 0;
    start_frame();
    wait_done(0);
    start = 1'b0;
    repeat (2) tick();
    check("rows_count", 32'(nvalid), 32'(25));

    // Abort during FETCH of window (2,3), then a clean frame.
    fill(0);
    mode = 0;
    nvalid = 0;
    start_frame();
    for (int i = 0; i < FRAME; i++) begin
      if (res_row == 3'd2 && res_col == 3'd3 && rd_en) break;
      tick();
    end
    repeat (5) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("aborted_results", 32'(nvalid), 32'(13));
    nvalid = 0;
    start_frame();
    wait_done(0);
    start = 1'b0;
    repeat (2) tick();
    check("after_abort_count", 32'(nvalid), 32'(25));

    // Random data with random start pulses throughout.
    for (int f = 0; f < 3; f++) begin
      fill(0);
      nvalid = 0;
      start_frame();
      wait_done(1);
      start = 1'b0;
      repeat (2) tick();
      check("random_count", 32'(nvalid), 32'(25));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
